// File: rtl/medidor_largura_pulso.sv
// Pulse-width meter: measures the high time of an asynchronous input in Clk cycles
// and reports one result per pulse with a single-cycle strobe.
module medidor_largura_pulso #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Entrada,
  output logic [WIDTH-1:0] Largura,
  output logic             Valido,
  output logic             Saturado,
  output logic             Ocupado
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ARMANDO = 2'd0,
    OCIOSO  = 2'd1,
    MEDINDO = 2'd2
  } estado_t;

  estado_t                r_estado;
  estado_t                w_estado_prox;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_cheio;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       w_cnt_prox;
  logic [WIDTH-1:0]       r_largura;
  logic [WIDTH-1:0]       w_largura_prox;
  logic                   r_valido;
  logic                   w_valido_prox;
  logic                   r_saturado;
  logic                   w_saturado_prox;
  logic                   r_ocupado;
  logic                   w_s;
  logic                   w_pronto;

  // r_cheio marks when the cleared synchronizer holds real samples again, so the
  // zeros left by reset are not mistaken for a low input while arming.
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_pronto = r_cheio[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync  <= '0;
      r_cheio <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], Entrada};
      r_cheio <= {r_cheio[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_estado   <= ARMANDO;
      r_cnt      <= '0;
      r_largura  <= '0;
      r_valido   <= 1'b0;
      r_saturado <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_estado   <= w_estado_prox;
      r_cnt      <= w_cnt_prox;
      r_largura  <= w_largura_prox;
      r_valido   <= w_valido_prox;
      r_saturado <= w_saturado_prox;
      r_ocupado  <= (w_estado_prox == MEDINDO);
    end
  end

  // Next-state and result logic; the count saturates instead of wrapping.
  always_comb begin
    w_estado_prox   = r_estado;
    w_cnt_prox      = r_cnt;
    w_largura_prox  = r_largura;
    w_saturado_prox = r_saturado;
    w_valido_prox   = 1'b0;
    case (r_estado)
      ARMANDO: begin
        if (w_pronto && !w_s) w_estado_prox = OCIOSO;
      end
      OCIOSO: begin
        if (w_s) begin
          w_estado_prox = MEDINDO;
          w_cnt_prox    = WIDTH'(1);
        end
      end
      MEDINDO: begin
        if (w_s) begin
          if (r_cnt != CNT_MAX) w_cnt_prox = r_cnt + WIDTH'(1);
        end else begin
          w_largura_prox  = r_cnt;
          w_saturado_prox = (r_cnt == CNT_MAX);
          w_valido_prox   = 1'b1;
          w_estado_prox   = OCIOSO;
        end
      end
      default: w_estado_prox = ARMANDO;
    endcase
  end

  assign Largura  = r_largura;
  assign Valido   = r_valido;
  assign Saturado = r_saturado;
  assign Ocupado  = r_ocupado;

endmodule

// File: tb/tb_medidor_largura_pulso.sv
// Directed and randomized checks for medidor_largura_pulso (WIDTH=28 and WIDTH=4 instances).
module tb_medidor_largura_pulso;

  logic        Clk;
  logic        Reset;
  logic        Entrada;
  logic [27:0] Largura;
  logic        Valido;
  logic        Saturado;
  logic        Ocupado;
  logic [3:0]  Largura4;
  logic        Valido4;
  logic        Saturado4;
  logic        Ocupado4;

  int n_pass  = 0;
  int n_total = 0;

  logic [27:0] q_larg[$];
  logic        q_sat[$];
  logic [3:0]  q4_larg[$];
  logic        q4_sat[$];
  logic        r_mon = 1'b0;
  int          ocup_cycles = 0;
  int          both_cycles = 0;

  medidor_largura_pulso #(.WIDTH(28), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Entrada(Entrada),
    .Largura(Largura), .Valido(Valido), .Saturado(Saturado), .Ocupado(Ocupado)
  );

  medidor_largura_pulso #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .Clk(Clk), .Reset(Reset), .Entrada(Entrada),
    .Largura(Largura4), .Valido(Valido4), .Saturado(Saturado4), .Ocupado(Ocupado4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Result capture away from the active edge
  always @(negedge Clk) begin
    if (Valido) begin
      q_larg.push_back(Largura);
      q_sat.push_back(Saturado);
    end
    if (Valido4) begin
      q4_larg.push_back(Largura4);
      q4_sat.push_back(Saturado4);
    end
    if (r_mon) begin
      if (Ocupado) ocup_cycles++;
      if (Ocupado && Valido) both_cycles++;
    end
  end

  task automatic clear_q();
    q_larg.delete(); q_sat.delete(); q4_larg.delete(); q4_sat.delete();
  endtask

  task automatic drive_pulse(input int n, input int gap);
    Entrada = 1'b1;
    repeat (n) @(negedge Clk);
    Entrada = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Entrada = 1'b0;
    repeat (3) @(negedge Clk);
    n_total++; if (Largura !== 28'd0) $display("FAIL reset_largura: got %0d expected 0", Largura); else n_pass++;
    n_total++; if (Valido !== 1'b0) $display("FAIL reset_valido: got %b expected 0", Valido); else n_pass++;
    n_total++; if (Saturado !== 1'b0) $display("FAIL reset_saturado: got %b expected 0", Saturado); else n_pass++;
    n_total++; if (Ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b expected 0", Ocupado); else n_pass++;
    n_total++; if (Ocupado4 !== 1'b0) $display("FAIL reset_ocupado4: got %b expected 0", Ocupado4); else n_pass++;
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_basic();
    clear_q();
    Entrada = 1'b1;
    repeat (5) @(negedge Clk);
    n_total++; if (Ocupado !== 1'b1) $display("FAIL basic_ocupado_mid: got %b expected 1", Ocupado); else n_pass++;
    Entrada = 1'b0;
    repeat (8) @(negedge Clk);
    n_total++; if (q_larg.size() != 1) $display("FAIL basic_count: got %0d expected 1", q_larg.size()); else n_pass++;
    n_total++; if (((q_larg.size() > 0) ? q_larg[0] : 28'd0) !== 28'd5)
      $display("FAIL basic_largura: got %0d expected 5", (q_larg.size() > 0) ? q_larg[0] : 28'd0); else n_pass++;
    n_total++; if (((q_sat.size() > 0) ? q_sat[0] : 1'bx) !== 1'b0)
      $display("FAIL basic_saturado: got %b expected 0", (q_sat.size() > 0) ? q_sat[0] : 1'bx); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_q();
    drive_pulse(1, 1);
    drive_pulse(3, 8);
    n_total++; if (q_larg.size() != 2) $display("FAIL b2b_count: got %0d expected 2", q_larg.size()); else n_pass++;
    n_total++; if (((q_larg.size() > 0) ? q_larg[0] : 28'd0) !== 28'd1)
      $display("FAIL b2b_first: got %0d expected 1", (q_larg.size() > 0) ? q_larg[0] : 28'd0); else n_pass++;
    n_total++; if (((q_larg.size() > 1) ? q_larg[1] : 28'd0) !== 28'd3)
      $display("FAIL b2b_second: got %0d expected 3", (q_larg.size() > 1) ? q_larg[1] : 28'd0); else n_pass++;
  endtask

  task automatic test_saturation();
    clear_q();
    drive_pulse(20, 8);
    drive_pulse(2, 8);
    n_total++; if (((q_larg.size() > 0) ? q_larg[0] : 28'd0) !== 28'd20)
      $display("FAIL sat_wide_largura: got %0d expected 20", (q_larg.size() > 0) ? q_larg[0] : 28'd0); else n_pass++;
    n_total++; if (((q_sat.size() > 0) ? q_sat[0] : 1'bx) !== 1'b0)
      $display("FAIL sat_wide_saturado: got %b expected 0", (q_sat.size() > 0) ? q_sat[0] : 1'bx); else n_pass++;
    n_total++; if (q4_larg.size() != 2) $display("FAIL sat4_count: got %0d expected 2", q4_larg.size()); else n_pass++;
    n_total++; if (((q4_larg.size() > 0) ? q4_larg[0] : 4'd0) !== 4'd15)
      $display("FAIL sat4_largura: got %0d expected 15", (q4_larg.size() > 0) ? q4_larg[0] : 4'd0); else n_pass++;
    n_total++; if (((q4_sat.size() > 0) ? q4_sat[0] : 1'bx) !== 1'b1)
      $display("FAIL sat4_saturado: got %b expected 1", (q4_sat.size() > 0) ? q4_sat[0] : 1'bx); else n_pass++;
    n_total++; if (((q4_larg.size() > 1) ? q4_larg[1] : 4'd0) !== 4'd2)
      $display("FAIL sat4_after_largura: got %0d expected 2", (q4_larg.size() > 1) ? q4_larg[1] : 4'd0); else n_pass++;
    n_total++; if (((q4_sat.size() > 1) ? q4_sat[1] : 1'bx) !== 1'b0)
      $display("FAIL sat4_after_saturado: got %b expected 0", (q4_sat.size() > 1) ? q4_sat[1] : 1'bx); else n_pass++;
  endtask

  task automatic test_high_through_reset();
    clear_q();
    Entrada = 1'b1;
    Reset   = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    Entrada = 1'b0;
    repeat (8) @(negedge Clk);
    n_total++; if (q_larg.size() != 0) $display("FAIL thru_reset_no_valido: got %0d expected 0", q_larg.size()); else n_pass++;
    n_total++; if (Largura !== 28'd0) $display("FAIL thru_reset_largura: got %0d expected 0", Largura); else n_pass++;
    n_total++; if (Ocupado !== 1'b0) $display("FAIL thru_reset_ocupado: got %b expected 0", Ocupado); else n_pass++;
    drive_pulse(4, 8);
    n_total++; if (q_larg.size() != 1) $display("FAIL thru_reset_next_count: got %0d expected 1", q_larg.size()); else n_pass++;
    n_total++; if (((q_larg.size() > 0) ? q_larg[0] : 28'd0) !== 28'd4)
      $display("FAIL thru_reset_next_largura: got %0d expected 4", (q_larg.size() > 0) ? q_larg[0] : 28'd0); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    clear_q();
    drive_pulse(7, 6);
    Entrada = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Entrada = 1'b0;
    repeat (8) @(negedge Clk);
    n_total++; if (q_larg.size() != 1) $display("FAIL mid_valido_count: got %0d expected 1", q_larg.size()); else n_pass++;
    n_total++; if (Largura !== 28'd0) $display("FAIL mid_largura: got %0d expected 0", Largura); else n_pass++;
    n_total++; if (Saturado !== 1'b0) $display("FAIL mid_saturado: got %b expected 0", Saturado); else n_pass++;
    n_total++; if (Ocupado !== 1'b0) $display("FAIL mid_ocupado: got %b expected 0", Ocupado); else n_pass++;
    n_total++; if (Valido !== 1'b0) $display("FAIL mid_valido: got %b expected 0", Valido); else n_pass++;
    drive_pulse(6, 8);
    n_total++; if (((q_larg.size() > 1) ? q_larg[1] : 28'd0) !== 28'd6)
      $display("FAIL mid_next_largura: got %0d expected 6", (q_larg.size() > 1) ? q_larg[1] : 28'd0); else n_pass++;
  endtask

  task automatic test_random();
    int exp_w[$];
    int sum_w;
    int w;
    int g;
    logic [27:0] got;
    clear_q();
    sum_w = 0;
    ocup_cycles = 0;
    both_cycles = 0;
    r_mon = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w = int'($urandom_range(200, 1));
      g = int'($urandom_range(4, 1));
      exp_w.push_back(w);
      sum_w += w;
      drive_pulse(w, g);
    end
    repeat (8) @(negedge Clk);
    r_mon = 1'b0;
    n_total++; if (q_larg.size() != exp_w.size())
      $display("FAIL rand_count: got %0d expected %0d", q_larg.size(), exp_w.size()); else n_pass++;
    for (int i = 0; i < exp_w.size(); i++) begin
      got = (q_larg.size() > i) ? q_larg[i] : 28'd0;
      n_total++; if (got !== 28'(exp_w[i]))
        $display("FAIL rand_width[%0d]: got %0d expected %0d", i, got, exp_w[i]); else n_pass++;
    end
    n_total++; if (ocup_cycles != sum_w)
      $display("FAIL rand_ocupado_cycles: got %0d expected %0d", ocup_cycles, sum_w); else n_pass++;
    n_total++; if (both_cycles != 0)
      $display("FAIL rand_ocupado_with_valido: got %0d expected 0", both_cycles); else n_pass++;
  endtask

  initial begin
    Reset   = 1'b1;
    Entrada = 1'b0;
    @(negedge Clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_high_through_reset();
    test_reset_mid_pulse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
